costas_loop_filter: RTL and testbench

- Upstream neighbour of the NCO phase stage.
- Takes post-mixer, low-pass-filtered baseband I/Q samples and computes the Costas phase error (BPSK or QPSK detector).
- Filters the error with a shift-gain proportional-integral (PI) loop filter.
- Emits a saturated signed correction word on a valid-qualified stream that drives the NCO feedback input directly.

---
 rtl/costas_pkg.sv | 36 +++
 rtl/costas_phase_detector.sv | 51 +++++
 rtl/costas_loop_filter.sv | 103 ++++++++++
 tb/tb_costas_loop_filter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared constants and saturating arithmetic helpers for the Costas loop filter.
// The helpers operate on a wide signed carrier; callers size-cast the result.
package costas_pkg;

   localparam logic MODE_BPSK = 1'b0;
   localparam logic MODE_QPSK = 1'b1;

   localparam logic [3:0] DEF_KP_SHIFT = 4'd2;
   localparam logic [3:0] DEF_KI_SHIFT = 4'd4;

   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   // Clamp x into the signed range of a w-bit word.
   function automatic wide_t sat_w(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
      return sat_w(a + b, w);
   endfunction

   function automatic wide_t sat_neg(input wide_t a, input int w);
      return sat_w(-a, w);
   endfunction

endpackage

// File: rtl/costas_phase_detector.sv
// Stage 1 of the Costas loop: BPSK/QPSK phase-error detector and its register.
// Sign decisions use the MSB, so zero is treated as positive.
module costas_phase_detector
   import costas_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_mode,
   input  logic signed [WIDTH-1:0] i_idata,
   input  logic signed [WIDTH-1:0] i_qdata,
   input  logic                    i_vld,
   output logic signed [WIDTH-1:0] o_e,
   output logic                    o_vld
);

   wide_t                   w_si_q;
   wide_t                   w_sq_i;
   logic signed [WIDTH-1:0] w_e;
   logic signed [WIDTH-1:0] r_e_p1;
   logic                    r_vld_p1;

   always_comb begin
      w_si_q = i_idata[WIDTH-1] ? -wide_t'(i_qdata) : wide_t'(i_qdata);
      w_sq_i = i_qdata[WIDTH-1] ? -wide_t'(i_idata) : wide_t'(i_idata);
      w_e    = '0;
      if (i_mode == MODE_QPSK)
         w_e = WIDTH'(sat_w((w_si_q - w_sq_i) >>> 1, WIDTH));
      else if (i_idata[WIDTH-1])
         w_e = WIDTH'(sat_neg(wide_t'(i_qdata), WIDTH));
      else
         w_e = i_qdata;
   end

   // ---- stage 1 register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_e_p1   <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= i_vld;
         if (i_vld)
            r_e_p1 <= w_e;
      end
   end

   assign o_e   = r_e_p1;
   assign o_vld = r_vld_p1;

endmodule

// File: rtl/costas_loop_filter.sv
// Costas phase-error detector followed by a shift-gain PI loop filter whose
// saturated output drives the NCO feedback input (3-clock latency, no stalls).
module costas_loop_filter
   import costas_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    MODE,
   input  logic [3:0]              KP_SHIFT,
   input  logic [3:0]              KI_SHIFT,
   input  logic                    INT_CLEAR,
   input  logic signed [WIDTH-1:0] i_tdata,
   input  logic signed [WIDTH-1:0] q_tdata,
   input  logic                    iq_tvalid,
   output logic signed [WIDTH-1:0] feedback_tdata,
   output logic                    feedback_tvalid,
   output logic                    integ_sat
);

   localparam int FRAC = ACC_WIDTH - WIDTH;

   logic signed [WIDTH-1:0]     w_e_p1;
   logic                        w_vld_p1;
   logic signed [WIDTH-1:0]     w_prop;
   wide_t                       w_inc;
   wide_t                       w_sum;
   logic signed [ACC_WIDTH-1:0] w_integ;
   logic                        w_clip;
   logic signed [WIDTH-1:0]     w_integ_hi;
   logic signed [WIDTH-1:0]     w_fb;

   logic signed [WIDTH-1:0]     r_prop_p2;
   logic signed [ACC_WIDTH-1:0] r_integ_p2;
   logic                        r_sat_p2;
   logic                        r_vld_p2;
   logic signed [WIDTH-1:0]     r_fb_p3;
   logic                        r_vld_p3;

   costas_phase_detector #(
      .WIDTH (WIDTH)
   ) u_detector (
      .clk     (clk),
      .rst     (rst),
      .i_mode  (MODE),
      .i_idata (i_tdata),
      .i_qdata (q_tdata),
      .i_vld   (iq_tvalid),
      .o_e     (w_e_p1),
      .o_vld   (w_vld_p1)
   );

   // Integrator input is the error aligned to the accumulator's fractional point.
   always_comb begin
      w_prop     = w_e_p1 >>> KP_SHIFT;
      w_inc      = (wide_t'(w_e_p1) <<< FRAC) >>> KI_SHIFT;
      w_sum      = wide_t'(r_integ_p2) + w_inc;
      w_integ    = ACC_WIDTH'(sat_w(w_sum, ACC_WIDTH));
      w_clip     = (wide_t'(w_integ) != w_sum);
      w_integ_hi = r_integ_p2[ACC_WIDTH-1:FRAC];
      w_fb       = WIDTH'(sat_add(wide_t'(r_prop_p2), wide_t'(w_integ_hi), WIDTH));
   end

   // ---- stage 2: proportional and integral terms ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prop_p2  <= '0;
         r_integ_p2 <= '0;
         r_sat_p2   <= 1'b0;
         r_vld_p2   <= 1'b0;
      end else begin
         r_vld_p2 <= w_vld_p1;
         if (w_vld_p1)
            r_prop_p2 <= w_prop;
         if (INT_CLEAR) begin
            r_integ_p2 <= '0;
            r_sat_p2   <= 1'b0;
         end else if (w_vld_p1) begin
            r_integ_p2 <= w_integ;
            r_sat_p2   <= w_clip;
         end
      end
   end

   // ---- stage 3: combined, saturated correction ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fb_p3  <= '0;
         r_vld_p3 <= 1'b0;
      end else begin
         r_vld_p3 <= r_vld_p2;
         if (r_vld_p2)
            r_fb_p3 <= w_fb;
      end
   end

   assign feedback_tdata  = r_fb_p3;
   assign feedback_tvalid = r_vld_p3;
   assign integ_sat       = r_sat_p2;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Bench for costas_loop_filter: directed scenarios plus randomized traffic,
// checked every clock against a sample-level arithmetic reference model.
module tb_costas_loop_filter;
   import costas_pkg::*;

   localparam int W  = 16;
   localparam int AW = 24;
   localparam int F  = AW - W;

   logic                clk = 1'b0;
   logic                rst;
   logic                MODE;
   logic [3:0]          KP_SHIFT;
   logic [3:0]          KI_SHIFT;
   logic                INT_CLEAR;
   logic signed [W-1:0] i_tdata;
   logic signed [W-1:0] q_tdata;
   logic                iq_tvalid;
   logic signed [W-1:0] feedback_tdata;
   logic                feedback_tvalid;
   logic                integ_sat;

   int ncmp = 0;
   int nerr = 0;

   bit cfg_mode;
   int cfg_kp;
   int cfg_ki;

   longint m_integ, m_prop, m_e_pend, m_out_d, m_nxt_d;
   bit     m_sat, m_pend_v, m_nxt_v, m_out_v;
   int     outs[$];

   costas_loop_filter #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .MODE            (MODE),
      .KP_SHIFT        (KP_SHIFT),
      .KI_SHIFT        (KI_SHIFT),
      .INT_CLEAR       (INT_CLEAR),
      .i_tdata         (i_tdata),
      .q_tdata         (q_tdata),
      .iq_tvalid       (iq_tvalid),
      .feedback_tdata  (feedback_tdata),
      .feedback_tvalid (feedback_tvalid),
      .integ_sat       (integ_sat)
   );

   always #5 clk = ~clk;

   // Floor division: truncation toward negative infinity.
   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0)))
         q = q - 1;
      return q;
   endfunction

   function automatic longint clamp(input longint x, input int w);
      longint hi, lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   function automatic longint sgn(input longint x);
      return (x >= 0) ? 1 : -1;
   endfunction

   function automatic longint detect(input longint i, input longint q, input bit mode);
      if (mode)
         return clamp(fdiv(sgn(i) * q - sgn(q) * i, 2), W);
      return clamp(sgn(i) * q, W);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: update the reference for this edge, drive inputs, compare after the edge.
   task automatic step(input longint i, input longint q, input bit v, input bit clr, input bit r);
      longint raw;
      if (r) begin
         m_integ = 0; m_prop = 0; m_sat = 0;
         m_pend_v = 0; m_nxt_v = 0; m_out_v = 0; m_out_d = 0;
      end else begin
         m_out_v = m_nxt_v;
         if (m_nxt_v) m_out_d = m_nxt_d;
         if (clr) begin
            m_integ = 0;
            m_sat   = 0;
         end
         if (m_pend_v) begin
            m_prop = fdiv(m_e_pend, longint'(1) << cfg_kp);
            if (!clr) begin
               raw     = m_integ + fdiv(m_e_pend * (longint'(1) << F), longint'(1) << cfg_ki);
               m_integ = clamp(raw, AW);
               m_sat   = (raw != m_integ);
            end
         end
         m_nxt_v  = m_pend_v;
         m_nxt_d  = clamp(m_prop + fdiv(m_integ, longint'(1) << F), W);
         m_pend_v = v;
         if (v) m_e_pend = detect(i, q, cfg_mode);
      end
      rst       = r;
      MODE      = cfg_mode;
      KP_SHIFT  = 4'(cfg_kp);
      KI_SHIFT  = 4'(cfg_ki);
      INT_CLEAR = clr;
      i_tdata   = W'(i);
      q_tdata   = W'(q);
      iq_tvalid = v;
      @(posedge clk);
      #1;
      chk("tvalid", feedback_tvalid, m_out_v);
      chk("tdata", $signed(feedback_tdata), m_out_d);
      chk("integ_sat", integ_sat, m_sat);
      if (feedback_tvalid === 1'b1)
         outs.push_back(int'($signed(feedback_tdata)));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(0, 0, 1'b0, 1'b0, 1'b1);
      step(0, 0, 1'b0, 1'b0, 1'b1);
      outs.delete();
   endtask

   function automatic longint rnd_sample();
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) return -32768;
      if (sel == 1) return 32767;
      if (sel == 2) return longint'($urandom_range(0, 3)) - 2;
      return longint'($signed(16'($urandom)));
   endfunction

   initial begin
      cfg_mode = MODE_BPSK;
      cfg_kp   = int'(DEF_KP_SHIFT);
      cfg_ki   = int'(DEF_KI_SHIFT);

      // Reset state
      do_reset();
      chk("rst_tvalid", feedback_tvalid, 1'b0);
      chk("rst_tdata", $signed(feedback_tdata), 0);
      chk("rst_sat", integ_sat, 1'b0);

      // BPSK ramp with a one-cycle integrator clear hitting the 5th sample
      for (int k = 0; k < 12; k++) step(1000, 200, 1'b1, (k == 5), 1'b0);
      idle(3);
      chk("ramp_count", outs.size(), 12);
      chk("ramp0", outs[0], 62);
      chk("ramp1", outs[1], 75);
      chk("ramp2", outs[2], 87);
      chk("ramp3", outs[3], 100);
      chk("clear_out", outs[4], 50);
      chk("restart0", outs[5], 62);
      chk("restart1", outs[6], 75);

      // QPSK single sample, then hold
      do_reset();
      cfg_mode = MODE_QPSK; cfg_kp = 0; cfg_ki = 15;
      step(-1000, 400, 1'b1, 1'b0, 1'b0);
      idle(5);
      chk("qpsk_out", outs[0], 300);
      chk("qpsk_hold", $signed(feedback_tdata), 300);
      chk("qpsk_hold_v", feedback_tvalid, 1'b0);

      // Integrator saturation and unwind
      do_reset();
      cfg_mode = MODE_BPSK; cfg_kp = 0; cfg_ki = 0;
      for (int k = 0; k < 4; k++) step(1, 32767, 1'b1, 1'b0, 1'b0);
      chk("sat_set", integ_sat, 1'b1);
      chk("sat_out", $signed(feedback_tdata), 32767);
      step(1, -32768, 1'b1, 1'b0, 1'b0);
      step(1, -32768, 1'b1, 1'b0, 1'b0);
      chk("sat_unwind", integ_sat, 1'b0);
      step(1, -32768, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("sat_o1", outs[1], 32767);

      // Negation edge: -(-32768) must clip, not wrap
      do_reset();
      cfg_mode = MODE_BPSK; cfg_kp = 0; cfg_ki = 15;
      step(-5, -32768, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("neg_edge", outs[0], 32767);

      // Gapped valid, then reset while a sample is in flight
      do_reset();
      cfg_mode = MODE_BPSK; cfg_kp = 2; cfg_ki = 4;
      for (int k = 0; k < 4; k++) begin
         step(1000, 200, 1'b1, 1'b0, 1'b0);
         idle(2);
      end
      chk("gap0", outs[0], 62);
      chk("gap1", outs[1], 75);
      chk("gap2", outs[2], 87);
      chk("gap3", outs[3], 100);
      step(1000, 200, 1'b1, 1'b0, 1'b0);
      step(1000, 200, 1'b1, 1'b0, 1'b1);
      chk("midrst_v", feedback_tvalid, 1'b0);
      chk("midrst_d", $signed(feedback_tdata), 0);
      idle(4);
      chk("no_stale", outs.size(), 4);
      for (int k = 0; k < 3; k++) begin
         step(1000, 200, 1'b1, 1'b0, 1'b0);
         idle(2);
      end
      chk("rst_restart0", outs[4], 62);
      chk("rst_restart2", outs[6], 87);

      // Randomized traffic with per-cycle control changes
      do_reset();
      for (int k = 0; k < 600; k++) begin
         cfg_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) cfg_kp = int'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) cfg_ki = int'($urandom_range(0, 15));
         step(rnd_sample(), rnd_sample(), 1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
